mem_test_master: RTL and testbench
==================================

MEM_TEST_MASTER -- requirements
Module: mem_test_master

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of the memory port.
REQ-002 SHALL have parameter DEPTH, default 64, number of memory words exercised.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for ready_i per request (1..65535).
REQ-005 SHALL have clk_i  input  1  single clock, all state updates on rising edge.
REQ-006 SHALL have rst_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have start_i  input  1  begin a test run; sampled only in IDLE.
REQ-008 SHALL have seed_i  input  WIDTH  pattern seed; latched in the cycle start_i is accepted.
REQ-009 SHALL have addr_o  output  ADDR_WIDTH  request address to memory.
REQ-010 SHALL have wdata_o  output  WIDTH  write data to memory.
REQ-011 SHALL have wr_rd_o  output  1  1 = write, 0 = read.
REQ-012 SHALL have valid_o  output  1  request valid.
REQ-013 SHALL have ready_i  input  1  memory has performed the request; read data valid in the same cycle.
REQ-014 SHALL have rdata_i  input  WIDTH  read data from memory.
REQ-015 SHALL have busy_o  output  1  run in progress.
REQ-016 SHALL have done_o  output  1  one-cycle pulse at end of run (pass, fail or timeout).
REQ-017 SHALL have pass_o  output  1  last run: zero mismatches and no timeout; held until next start.
REQ-018 SHALL have timeout_o  output  1  last run aborted on timeout; held until next start.
REQ-019 SHALL have err_cnt_o  output  ADDR_WIDTH+1  mismatch count of last/current run.
REQ-020 SHALL have first_err_addr_o  output  ADDR_WIDTH  address of first mismatch; 0 if none.

Function
REQ-021 SHALL implement states IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
REQ-022 IDLE: start_i=1 -> latch seed, clear err_cnt_o/first_err_addr_o/pass_o/timeout_o, addr=0, go WR_REQ; busy_o=1 from next cycle.
REQ-023 Pattern SHALL be pat(a) = seed XOR zero-extended a, truncated to WIDTH.
REQ-024 WR_REQ: valid_o=1, wr_rd_o=1, wdata_o=pat(addr); addr_o/wdata_o/wr_rd_o SHALL be stable while valid_o=1.
REQ-025 A request SHALL complete in the first cycle ready_i is sampled 1 while valid_o=1; next cycle valid_o=0.
REQ-026 Gap states: valid_o=0; SHALL wait until ready_i is sampled 0 before issuing next request (memory ready is registered and lags valid).
REQ-027 WR_GAP exit on ready_i=0: addr<DEPTH-1 -> addr+1, WR_REQ; addr=DEPTH-1 -> addr=0, RD_REQ.
REQ-028 RD_REQ: valid_o=1, wr_rd_o=0, wdata_o=0; on completion compare rdata_i with pat(addr).
REQ-029 Mismatch: err_cnt_o+1 (saturating at 2^(ADDR_WIDTH+1)-1); if first mismatch of run, first_err_addr_o=addr.
REQ-030 RD_GAP exit on ready_i=0: addr<DEPTH-1 -> addr+1, RD_REQ; addr=DEPTH-1 -> DONE.
REQ-031 Watchdog SHALL count cycles in each REQ state; reset on entry; reaching TIMEOUT without ready_i -> timeout_o=1, valid_o=0, go DONE.
REQ-032 Gap states SHALL use same watchdog; ready_i stuck 1 for TIMEOUT cycles -> timeout.
REQ-033 DONE: done_o=1 for one cycle, pass_o=(err_cnt==0 && !timeout), busy_o=0 next cycle, return IDLE.
REQ-034 start_i while busy_o=1 SHALL be ignored.
REQ-035 Address wrap: addr SHALL never exceed DEPTH-1; non-power-of-two DEPTH supported.
REQ-036 Run length without stalls: each request >= 3 cycles incl. gap; total cycles deterministic per memory latency.

Reset
REQ-037 rst_i=0 SHALL immediately force IDLE, valid_o=0, wr_rd_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, pass_o=0, timeout_o=0, err_cnt_o=0, first_err_addr_o=0.
REQ-038 Reset mid-run SHALL abort without done_o; after release, block idles until start_i.

Verification
REQ-039 Ideal memory (1-cycle registered ready/rdata), seed=16'hA5A5, start pulse -> 64 writes then 64 reads, addr 0..63, done_o once, pass_o=1, err_cnt_o=0.
REQ-040 Memory corrupting reads at addr 5 and 40 -> err_cnt_o=2, first_err_addr_o=5, pass_o=0.
REQ-041 ready_i held 0 -> after TIMEOUT=255 cycles in WR_REQ addr 0: timeout_o=1, done_o pulse, pass_o=0, valid_o=0.
REQ-042 Random 0-3 cycle ready stall -> request fields stable while valid_o=1; exactly one write and one read per address; pass_o=1.
REQ-043 rst_i low during read of addr 20 -> all outputs at reset values asynchronously; no done_o; new start runs full test, pass_o=1.
REQ-044 start_i pulsed during busy_o=1 -> no effect on sequence or seed.

Source files
------------

// File: rtl/mem_test_master_if.sv
// Request/response bus between the memory test master and the memory under test.
// Signal names carry the master's direction suffixes.
interface mem_test_master_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [WIDTH-1:0]      wdata_o;
    logic                  wr_rd_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [WIDTH-1:0]      rdata_i;

    modport master (
        output addr_o, wdata_o, wr_rd_o, valid_o,
        input  ready_i, rdata_i
    );

    modport slave (
        input  addr_o, wdata_o, wr_rd_o, valid_o,
        output ready_i, rdata_i
    );
endinterface

// File: rtl/mem_test_master.sv
// Memory test master: writes seed^addr to every word, reads everything back and
// counts mismatches, with a per-state watchdog on the memory handshake.
module mem_test_master #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      seed_i,
    mem_test_master_if.master     mem,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_cnt_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_REQ = 3'd1,
        S_WR_GAP = 3'd2,
        S_RD_REQ = 3'd3,
        S_RD_GAP = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = {(ADDR_WIDTH+1){1'b1}};
    localparam logic [WIDTH-1:0]      DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [15:0]           WD_LIMIT  = 16'(TIMEOUT - 1);

    function automatic logic [WIDTH-1:0] pat(input logic [WIDTH-1:0] s,
                                             input logic [ADDR_WIDTH-1:0] a);
        return s ^ WIDTH'(a);
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      seed_q, seed_d;
    logic [15:0]           wd_q, wd_d;
    logic [ADDR_WIDTH:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  tmo_s;
    logic                  wd_expired_s;

    assign wd_expired_s = (wd_q == WD_LIMIT);

    // Next-state and registered-output computation for the test sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        seed_d    = seed_q;
        wd_d      = wd_q;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        wr_rd_d   = wr_rd_q;
        wdata_d   = wdata_q;
        tmo_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WR_REQ;
                    seed_d    = seed_i;
                    addr_d    = ADDR_ZERO;
                    err_cnt_d = ERR_ZERO;
                    first_d   = ADDR_ZERO;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    wr_rd_d   = 1'b1;
                    wdata_d   = pat(seed_i, ADDR_ZERO);
                    wd_d      = 16'd0;
                end else begin
                    wd_d = 16'd0;
                end
            end
            S_WR_REQ: begin
                if (mem.ready_i) begin
                    state_d = S_WR_GAP;
                    valid_d = 1'b0;
                    wd_d    = 16'd0;
                end else if (wd_expired_s) begin
                    tmo_s = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            // Memory ready lags valid by a register, so wait for it to fall before the next request.
            S_WR_GAP: begin
                if (!mem.ready_i) begin
                    wd_d    = 16'd0;
                    valid_d = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = ADDR_ZERO;
                        state_d = S_RD_REQ;
                        wr_rd_d = 1'b0;
                        wdata_d = DATA_ZERO;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_WR_REQ;
                        wdata_d = pat(seed_q, addr_q + ADDR_ONE);
                    end
                end else if (wd_expired_s) begin
                    tmo_s = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_RD_REQ: begin
                if (mem.ready_i) begin
                    state_d = S_RD_GAP;
                    valid_d = 1'b0;
                    wd_d    = 16'd0;
                    if (mem.rdata_i != pat(seed_q, addr_q)) begin
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ERR_ONE;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                        if (err_cnt_q == ERR_ZERO) begin
                            first_d = addr_q;
                        end else begin
                            first_d = first_q;
                        end
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                end else if (wd_expired_s) begin
                    tmo_s = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_RD_GAP: begin
                if (!mem.ready_i) begin
                    wd_d = 16'd0;
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_q == ERR_ZERO);
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_RD_REQ;
                        valid_d = 1'b1;
                    end
                end else if (wd_expired_s) begin
                    tmo_s = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (tmo_s) begin
            state_d   = S_DONE;
            valid_d   = 1'b0;
            timeout_d = 1'b1;
            done_d    = 1'b1;
            pass_d    = 1'b0;
        end else begin
        end
    end

    // State and output registers; reset drops everything to idle immediately.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= ADDR_ZERO;
            seed_q    <= DATA_ZERO;
            wd_q      <= 16'd0;
            err_cnt_q <= ERR_ZERO;
            first_q   <= ADDR_ZERO;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            wr_rd_q   <= 1'b0;
            wdata_q   <= DATA_ZERO;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            seed_q    <= seed_d;
            wd_q      <= wd_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            wr_rd_q   <= wr_rd_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem.addr_o       = addr_q;
    assign mem.wdata_o      = wdata_q;
    assign mem.wr_rd_o      = wr_rd_q;
    assign mem.valid_o      = valid_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_mem_test_master.sv
// Bench for mem_test_master: a registered-ready memory model feeds the DUT and a
// transaction-level model predicts every handshake and each end-of-run result.
module tb_mem_test_master;
    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int TMO   = 255;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [WIDTH-1:0] seed_i;
    logic             busy, done, pass, tmo_o;
    logic [AW:0]      err_cnt;
    logic [AW-1:0]    first_err;

    mem_test_master_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) bus();

    mem_test_master #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .seed_i(seed_i), .mem(bus),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo_o),
        .err_cnt_o(err_cnt), .first_err_addr_o(first_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: mode 0 ideal, 1 random 0-3 stall, 2 ready stuck 0, 3 ready stuck 1
    logic [WIDTH-1:0] mem_arr [DEPTH];
    bit               corrupt [DEPTH];
    int               mem_mode;
    int               wait_cnt;

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            bus.ready_i <= 1'b0;
            bus.rdata_i <= '0;
            wait_cnt    <= 0;
        end else if (mem_mode == 2) begin
            bus.ready_i <= 1'b0;
        end else if (mem_mode == 3) begin
            bus.ready_i <= 1'b1;
        end else if (bus.valid_o && !bus.ready_i) begin
            if (wait_cnt > 0) begin
                wait_cnt <= wait_cnt - 1;
            end else begin
                bus.ready_i <= 1'b1;
                if (bus.wr_rd_o) mem_arr[bus.addr_o] <= bus.wdata_o;
                else bus.rdata_i <= mem_arr[bus.addr_o] ^ (corrupt[bus.addr_o] ? 16'h0100 : 16'h0000);
                wait_cnt <= (mem_mode == 1) ? int'($urandom_range(3, 0)) : 0;
            end
        end else begin
            bus.ready_i <= 1'b0;
        end
    end

    // Transaction model state
    logic [WIDTH-1:0] run_seed;
    bit               exp_timeout;
    int               exp_txns;
    int               txn_idx, model_err, model_first, done_cnt;
    int               run_cycles, last_run_cycles;
    logic             prev_valid, prev_ready, prev_wr;
    logic [AW-1:0]    prev_addr;
    logic [WIDTH-1:0] prev_wdata;

    initial begin
        done_cnt = 0; run_cycles = 0; last_run_cycles = 0;
        txn_idx = 0; model_err = 0; model_first = 0; prev_valid = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst_i || !busy) begin
            txn_idx = 0; model_err = 0; model_first = 0;
        end
        if (!rst_i) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            run_cycles = 0;
        end else begin
            if (busy) run_cycles++;
            else if (run_cycles != 0) begin
                last_run_cycles = run_cycles;
                run_cycles = 0;
            end
            if (prev_valid && !prev_ready && !tmo_o) begin
                check("hold_valid", bus.valid_o, 1);
                check("hold_addr", bus.addr_o, prev_addr);
                check("hold_wdata", bus.wdata_o, prev_wdata);
                check("hold_dir", bus.wr_rd_o, prev_wr);
            end
            if (prev_valid && prev_ready) check("drop_valid", bus.valid_o, 0);
            if (bus.valid_o && bus.ready_i) begin
                if (txn_idx < 2 * DEPTH) begin
                    int a;
                    bit is_wr;
                    a = txn_idx % DEPTH;
                    is_wr = (txn_idx < DEPTH);
                    check("txn_addr", bus.addr_o, a);
                    check("txn_dir", bus.wr_rd_o, is_wr);
                    check("txn_wdata", bus.wdata_o, is_wr ? 32'(run_seed ^ 16'(a)) : 32'd0);
                    if (!is_wr && corrupt[a]) begin
                        if (model_err == 0) model_first = a;
                        model_err++;
                    end
                end else begin
                    check("txn_extra", txn_idx, 2 * DEPTH - 1);
                end
                txn_idx++;
            end
            if (done) begin
                done_cnt++;
                check("done_txns", txn_idx, exp_txns);
                check("done_err_cnt", err_cnt, model_err);
                check("done_first_err", first_err, model_first);
                check("done_timeout", tmo_o, exp_timeout);
                check("done_pass", pass, (!exp_timeout && model_err == 0));
            end
            prev_valid = bus.valid_o;
            prev_ready = bus.ready_i;
            prev_addr  = bus.addr_o;
            prev_wdata = bus.wdata_o;
            prev_wr    = bus.wr_rd_o;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, bus.valid_o, 0);
        check({tag, "_wr_rd"}, bus.wr_rd_o, 0);
        check({tag, "_addr"}, bus.addr_o, 0);
        check({tag, "_wdata"}, bus.wdata_o, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_timeout"}, tmo_o, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
        check({tag, "_first_err"}, first_err, 0);
    endtask

    task automatic run_test(input logic [WIDTH-1:0] seed, input int budget);
        int  d0;
        bit  got;
        d0 = done_cnt;
        run_seed = seed;
        seed_i = seed;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seed_i = ~seed;
        check("start_busy", busy, 1);
        check("start_pass_clr", pass, 0);
        check("start_tmo_clr", tmo_o, 0);
        check("start_err_clr", err_cnt, 0);
        check("start_first_wdata", bus.wdata_o, seed);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("run_done_seen", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int d0;
        bit found;
        rst_i = 1'b0; start_i = 1'b0; seed_i = '0; mem_mode = 0;
        for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
        exp_timeout = 1'b0; exp_txns = 2 * DEPTH; run_seed = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal memory: 128 requests of 3 cycles each plus the DONE cycle
        run_test(16'hA5A5, 1000);
        check("r1_pass", pass, 1);
        check("r1_err_cnt", err_cnt, 0);
        check("r1_first", first_err, 0);
        check("r1_cycles", last_run_cycles, 385);
        repeat (5) @(negedge clk);
        check("r1_pass_held", pass, 1);

        // Corrupted reads at 5 and 40
        corrupt[5] = 1'b1; corrupt[40] = 1'b1;
        run_test(16'h1234, 1000);
        check("r2_err_cnt", err_cnt, 2);
        check("r2_first", first_err, 5);
        check("r2_pass", pass, 0);
        corrupt[5] = 1'b0; corrupt[40] = 1'b0;

        // Random stalls plus a start pulse with a different seed mid-run
        mem_mode = 1;
        fork
            run_test(16'hFFFF, 2000);
            begin
                repeat (50) @(negedge clk);
                start_i = 1'b1;
                seed_i = 16'h0F0F;
                @(negedge clk);
                start_i = 1'b0;
            end
        join
        check("r3_pass", pass, 1);
        check("r3_err_cnt", err_cnt, 0);

        // ready stuck low: 255 cycles in WR_REQ then DONE
        mem_mode = 2; exp_timeout = 1'b1; exp_txns = 0;
        run_test(16'h0001, 400);
        check("r4_timeout", tmo_o, 1);
        check("r4_pass", pass, 0);
        check("r4_valid", bus.valid_o, 0);
        check("r4_cycles", last_run_cycles, 256);

        // ready stuck high: first write completes, then 255 gap cycles
        mem_mode = 3; exp_txns = 1;
        run_test(16'h0002, 400);
        check("r5_timeout", tmo_o, 1);
        check("r5_pass", pass, 0);
        check("r5_cycles", last_run_cycles, 257);
        mem_mode = 0; exp_timeout = 1'b0; exp_txns = 2 * DEPTH;
        repeat (3) @(negedge clk);

        // Asynchronous reset during the read of address 20
        d0 = done_cnt;
        run_seed = 16'h5A5A; seed_i = 16'h5A5A; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.valid_o && !bus.wr_rd_o && bus.addr_o == 6'd20) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("r6_reached_rd20", found, 1);
        #2 rst_i = 1'b0;
        #1 check_reset("midrun");
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (5) @(negedge clk);
        check("r6_no_done", done_cnt - d0, 0);
        check("r6_idle", busy, 0);
        run_test(16'h5A5A, 1000);
        check("r6_pass", pass, 1);
        check("r6_cycles", last_run_cycles, 385);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
